// File: rtl/traffic_pkg.sv
// Shared light-code constants, default phase durations and the phase-class helper
// for the traffic light controller and its phase timer.
package traffic_pkg;

   localparam logic [1:0] G_MAIN_GRN = 2'b00;
   localparam logic [1:0] G_MAIN_YEL = 2'b01;
   localparam logic [1:0] G_SIDE_GRN = 2'b11;
   localparam logic [1:0] G_SIDE_YEL = 2'b10;

   localparam int unsigned DEF_LONG_S  = 25;
   localparam int unsigned DEF_SHORT_S = 4;

   // Green phases have equal code bits; yellow phases differ.
   function automatic logic is_long(input logic [1:0] code);
      return ~(code[1] ^ code[0]);
   endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Prescaler that emits a one-cycle tick every P_TICK_DIV enabled cycles.
// A synchronous clear restarts the count and suppresses the tick of that cycle.
module traffic_tick_gen #(
   parameter int unsigned P_TICK_DIV = 50_000_000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic clear_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned PrescW = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;
   localparam logic [PrescW-1:0] PrescMax = PrescW'(P_TICK_DIV - 1);

   logic [PrescW-1:0] presc_q, presc_d;
   logic              at_max;

   always_comb begin
      at_max  = (presc_q == PrescMax);
      tick_o  = en_i & ~clear_i & at_max;
      presc_d = presc_q;
      if (clear_i) begin
         presc_d = '0;
      end else if (en_i) begin
         presc_d = at_max ? '0 : presc_q + PrescW'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer for the traffic controller: watches the light code and produces the
// long (green) and short (yellow) timer-active flags plus the seconds remaining.
module traffic_phase_timer
   import traffic_pkg::*;
#(
   parameter int unsigned P_TICK_DIV = 50_000_000,
   parameter int unsigned P_LONG_S   = DEF_LONG_S,
   parameter int unsigned P_SHORT_S  = DEF_SHORT_S
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [1:0] i_G,
   output logic       o_Tl,
   output logic       o_Ts,
   output logic [7:0] o_remaining
);

   localparam logic [7:0] LongLd  = 8'(P_LONG_S);
   localparam logic [7:0] ShortLd = 8'(P_SHORT_S);

   logic [1:0] g_q, g_d;
   logic [7:0] sec_cnt_q, sec_cnt_d;
   logic       chg, cnt_nz, tick, long_ph, active;

   traffic_tick_gen #(
      .P_TICK_DIV (P_TICK_DIV)
   ) u_tick_gen (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .clear_i (chg),
      .en_i    (cnt_nz),
      .tick_o  (tick)
   );

   always_comb begin
      chg     = (i_G != g_q);
      long_ph = is_long(i_G);
      cnt_nz  = (sec_cnt_q != 8'd0);
      // A code change keeps the flag up so the controller sees it on the very next edge.
      active  = chg | cnt_nz;

      // Reset forces the main-green timer view regardless of the incoming code.
      o_Tl        = i_reset | (long_ph & active);
      o_Ts        = ~i_reset & ~long_ph & active;
      o_remaining = sec_cnt_q;

      g_d       = g_q;
      sec_cnt_d = sec_cnt_q;
      if (chg) begin
         g_d       = i_G;
         sec_cnt_d = long_ph ? LongLd : ShortLd;
      end else if (tick) begin
         sec_cnt_d = sec_cnt_q - 8'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         g_q       <= G_MAIN_GRN;
         sec_cnt_q <= LongLd;
      end else begin
         g_q       <= g_d;
         sec_cnt_q <= sec_cnt_d;
      end
   end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Randomized and closed-loop bench for traffic_phase_timer: two instances with different
// tick divisors, checked every cycle against an elapsed-time reference model.
module tb_traffic_phase_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] g;
   logic       tl0, ts0, tl1, ts1;
   logic [7:0] rem0, rem1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Per-instance model: code last taken, cycle the current countdown started, its length.
   int m_last   [2];
   int m_origin [2];
   int m_dur    [2];

   always #5 clk = ~clk;

   traffic_phase_timer #(
      .P_TICK_DIV (4),
      .P_LONG_S   (5),
      .P_SHORT_S  (2)
   ) u_dut0 (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_G         (g),
      .o_Tl        (tl0),
      .o_Ts        (ts0),
      .o_remaining (rem0)
   );

   traffic_phase_timer #(
      .P_TICK_DIV (1),
      .P_LONG_S   (5),
      .P_SHORT_S  (1)
   ) u_dut1 (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_G         (g),
      .o_Tl        (tl1),
      .o_Ts        (ts1),
      .o_remaining (rem1)
   );

   function automatic int p_div(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   function automatic int p_short(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic bit code_long(input logic [1:0] c);
      return (c == 2'b00) || (c == 2'b11);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   // Seconds left = duration minus whole ticks elapsed since the countdown origin, floored at 0.
   function automatic void model_exp(input int k, output int rem, output bit tl, output bit ts);
      bit chg;
      bit lng;
      bit act;
      if (rst) begin
         rem = 5;
         tl  = 1'b1;
         ts  = 1'b0;
      end else begin
         rem = m_dur[k] - (cyc - m_origin[k]) / p_div(k);
         if (rem < 0) rem = 0;
         chg = (int'(g) != m_last[k]);
         lng = code_long(g);
         act = chg || (rem != 0);
         tl  = lng && act;
         ts  = !lng && act;
      end
   endfunction

   task automatic check_all(input string when);
      int rem;
      bit tl;
      bit ts;
      for (int k = 0; k < 2; k++) begin
         model_exp(k, rem, tl, ts);
         if (k == 0) begin
            check_val({when, "_rem0"}, 32'(rem0), 32'(rem));
            check_val({when, "_tl0"}, 32'(tl0), 32'(tl));
            check_val({when, "_ts0"}, 32'(ts0), 32'(ts));
         end else begin
            check_val({when, "_rem1"}, 32'(rem1), 32'(rem));
            check_val({when, "_tl1"}, 32'(tl1), 32'(tl));
            check_val({when, "_ts1"}, 32'(ts1), 32'(ts));
         end
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_last[k]   = 0;
            m_dur[k]    = 5;
            m_origin[k] = cyc + 1;
         end else if (int'(g) != m_last[k]) begin
            m_last[k]   = int'(g);
            m_dur[k]    = code_long(g) ? 5 : p_short(k);
            m_origin[k] = cyc + 1;
         end
      end
      cyc++;
   endtask

   task automatic run_cycle();
      @(negedge clk);
      check_all("neg");
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      int len;
      int last_change;
      int dw[$];
      int exp_dw[8];
      logic [1:0] nxt;

      rst = 1'b1;
      g   = 2'b00;
      for (int k = 0; k < 2; k++) begin
         m_last[k]   = 0;
         m_dur[k]    = 5;
         m_origin[k] = 0;
      end
      #1;
      check_all("rst");
      repeat (3) run_cycle();
      rst = 1'b0;
      repeat (25) run_cycle();

      // Random code segments, some long enough to expire, with occasional async resets.
      for (int seg = 0; seg < 45; seg++) begin
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            #1;
            check_all("arst");
            run_cycle();
            rst = 1'b0;
         end else begin
            g = 2'($urandom_range(0, 3));
         end
         len = int'($urandom_range(1, 28));
         repeat (len) run_cycle();
      end

      // Closed loop: the bench plays the controller (side request always present).
      rst = 1'b1;
      g   = 2'b00;
      run_cycle();
      rst = 1'b0;
      last_change = cyc;
      repeat (140) begin
         @(negedge clk);
         check_all("loop");
         nxt = g;
         case (g)
            2'b00:   if (!tl0) nxt = 2'b01;
            2'b01:   if (!ts0) nxt = 2'b11;
            2'b11:   if (!tl0) nxt = 2'b10;
            default: if (!ts0) nxt = 2'b00;
         endcase
         @(posedge clk);
         model_edge();
         #1;
         if (nxt != g) begin
            dw.push_back(cyc - last_change);
            last_change = cyc;
            g = nxt;
         end
      end
      exp_dw = '{21, 10, 22, 10, 22, 10, 22, 10};
      for (int i = 0; i < 8; i++) begin
         check_val("dwell", (i < dw.size()) ? 32'(dw[i]) : 32'hFFFF_FFFF, 32'(exp_dw[i]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
- Timer source for the traffic light controller `Traffic_Sequential`.
- Watches the controller's light code o_G (fed back as i_G) and generates the long-timer (Tl) and short-timer (Ts) signals that the controller consumes.
- Long timer runs in the green phases (codes 00, 11); short timer runs in the yellow phases (codes 01, 10).
- Sits beside the controller at top level, closing the FSM/timer loop.

Parameters:
- P_TICK_DIV, 50_000_000, i_clk cycles per one-second tick (>=1).
- P_LONG_S, 25, long-timer duration in seconds (1..255).
- P_SHORT_S, 4, short-timer duration in seconds (1..255).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_G  in  2  current light code from the controller: 00 main green, 01 main yellow, 11 side green, 10 side yellow.
- o_Tl  out  1  long timer active (to controller i_Tl).
- o_Ts  out  1  short timer active (to controller i_Ts).
- o_remaining  out  8  whole seconds left in the current phase timer (display/debug).

Behaviour:
- Phase class: long = ~(i_G[1]^i_G[0]); short = i_G[1]^i_G[0].
- Registered state:
  - g_q[1:0]: last seen code.
  - sec_cnt[7:0]: seconds left.
  - presc: prescaler, width clog2(P_TICK_DIV), min 1.
- Reset (async): g_q=00, sec_cnt=P_LONG_S, presc=0. Outputs during and after reset: o_Tl=1, o_Ts=0, o_remaining=P_LONG_S. The controller resets to 00, so the long timer starts at reset.
- Change detect: chg = (i_G != g_q), combinational.
- Outputs, combinational (must react in the same cycle the code changes, because the controller samples the timer on the next edge):
  - o_Tl = long & (chg | sec_cnt != 0).
  - o_Ts = short & (chg | sec_cnt != 0).
  - o_remaining = sec_cnt.
- Edge where chg=1 (reload), which takes priority over any tick:
  - g_q <= i_G.
  - presc <= 0.
  - sec_cnt <= P_LONG_S if long, else P_SHORT_S.
- Edge where chg=0 and sec_cnt != 0:
  - tick = (presc == P_TICK_DIV-1).
  - presc <= tick ? 0 : presc+1.
  - On tick, sec_cnt <= sec_cnt-1.
- Edge where chg=0 and sec_cnt == 0: hold. Prescaler frozen at its value; outputs low until the next code change.
- Timing: the active output is high for exactly 1 + N*P_TICK_DIV cycles, counted from the change cycle inclusive (N = phase duration).
  - First tick occurs P_TICK_DIV cycles after the reload edge.
  - After reset release, the first tick is on cycle P_TICK_DIV-1, so o_Tl is high for P_LONG_S*P_TICK_DIV cycles.
- P_TICK_DIV=1: tick every cycle.
- Any code change reloads, including mid-count, illegal jumps (e.g. 00->11) and same-class changes.
- Reset mid-count: immediate return to reset values regardless of i_G. If i_G != 00 after release, a reload occurs on the first edge.
- sec_cnt never wraps below 0.
- o_Tl and o_Ts are never both 1.

Decomposition:
- Shared package traffic_pkg holds:
  - The light-code constants G_MAIN_GRN=00, G_MAIN_YEL=01, G_SIDE_GRN=11, G_SIDE_YEL=10.
  - The default durations 25/4.
  - An is_long(code) function.
- One sub-module, traffic_tick_gen:
  - Prescaler producing a one-cycle tick.
  - Inputs: synchronous clear (driven by chg) and enable (sec_cnt != 0).

Test Plan (P_TICK_DIV=4, P_LONG_S=5, P_SHORT_S=2 unless noted):
1. Assert reset with i_G=00 -> o_Tl=1, o_Ts=0, o_remaining=5 while held. After release (cycle 0), o_remaining steps 4,3,2,1,0 at cycles 4,8,12,16,20, and o_Tl falls at cycle 20.
2. With the timer expired, drive i_G 00->01 at cycle k -> o_Ts=1 and o_Tl=0 at cycle k. o_remaining=2 at k+1, 1 at k+5, 0 at k+9. o_Ts high for exactly 9 cycles (k..k+8).
3. Drive i_G 01->11 while o_remaining=1 -> o_Tl=1 and o_Ts=0 same cycle; o_remaining=5 on the next cycle; pending tick discarded.
4. Assert reset asynchronously mid-count with i_G=10 -> o_remaining=5 and o_Tl=1 immediately, without waiting for a clock. After release with i_G still 10, the next edge reloads to 2 and o_Ts=1.
5. Closed loop with `Traffic_Sequential`, i_Vs=1, reset released at cycle 0 -> codes cycle 00,01,11,10,00… Dwell lengths in cycles:
   - 00: 21 first time after reset (20 ticking cycles plus one sampling edge); 22 on every later entry.
   - 01: 10.
   - 11: 22.
   - 10: 10.
6. P_TICK_DIV=1, P_SHORT_S=1, i_G 00->10 -> o_Ts high for exactly 2 cycles; o_remaining goes 1 then 0.
